// File: rtl/vga_sync_decoder_if.sv
// VGA receive-side bundle: incoming sync/blank/colour and decoded outputs.
// The master drives video in; the slave (decoder) drives the results.
interface vga_sync_decoder_if #(
  parameter int CNT_W = 12
);
  logic             iVGA_HS;
  logic             iVGA_VS;
  logic             iVGA_BLANK;
  logic [9:0]       iVGA_R;
  logic [9:0]       iVGA_G;
  logic [9:0]       iVGA_B;
  logic [9:0]       oCoord_X;
  logic [9:0]       oCoord_Y;
  logic [9:0]       oRed;
  logic [9:0]       oGreen;
  logic [9:0]       oBlue;
  logic             oPixel_Valid;
  logic             oFrame_Start;
  logic [CNT_W-1:0] oH_Total;
  logic [CNT_W-1:0] oV_Total;
  logic             oLocked;
  logic             oTiming_Err;
  logic [15:0]      oFrame_CRC;

  modport master (
    output iVGA_HS, iVGA_VS, iVGA_BLANK,
    output iVGA_R, iVGA_G, iVGA_B,
    input  oCoord_X, oCoord_Y,
    input  oRed, oGreen, oBlue,
    input  oPixel_Valid, oFrame_Start,
    input  oH_Total, oV_Total,
    input  oLocked, oTiming_Err, oFrame_CRC
  );

  modport slave (
    input  iVGA_HS, iVGA_VS, iVGA_BLANK,
    input  iVGA_R, iVGA_G, iVGA_B,
    output oCoord_X, oCoord_Y,
    output oRed, oGreen, oBlue,
    output oPixel_Valid, oFrame_Start,
    output oH_Total, oV_Total,
    output oLocked, oTiming_Err, oFrame_CRC
  );
endinterface

// File: rtl/vga_sync_decoder.sv
// VGA sync decoder: measures timing, locks, rebuilds X/Y and colour.
// Optional per-frame CRC-16 of pixel data when VGA_DEC_CRC_EN is defined.
module vga_sync_decoder #(
  parameter int H_ACTIVE    = 640,
  parameter int V_ACTIVE    = 480,
  parameter int CNT_W       = 12,
  parameter int LOCK_FRAMES = 2
) (
  input logic iCLK,
  input logic iRST,
  vga_sync_decoder_if.slave bus
);

  typedef enum logic [1:0] {
    SEARCH,
    MEASURE,
    LOCKED
  } state_t;

  localparam int MW = $clog2(LOCK_FRAMES + 1);
  localparam logic [MW-1:0] LOCK_M = MW'(LOCK_FRAMES - 1);
  localparam logic [CNT_W-1:0] CMAX = '1;
  localparam logic [9:0] PMAX = '1;
  localparam logic [9:0] XA = 10'(H_ACTIVE);
  localparam logic [9:0] YA = 10'(V_ACTIVE);

  logic hs1, hs2, vs1, vs2, bl1;
  logic [9:0] r1, g1, b1;

  logic [CNT_W-1:0] h_cnt, line_cnt, last_h;
  logic [CNT_W-1:0] h_inc, l_inc;
  logic [CNT_W-1:0] cand_h, cand_v;
  logic [CNT_W-1:0] prev_h, prev_v;
  logic [9:0] x_cnt, y_cnt;
  logic [9:0] x_pix, y_pix, x_inc, y_inc;
  logic line_act, skip_h, dirty;
  logic hs_fall, vs_fall;
  logic e_h, e_v, e_x, e_y;

  state_t state_q, state_d;
  logic [MW-1:0] match_cnt, cnt_d;
  logic [CNT_W-1:0] ph_d, pv_d;
  logic [CNT_W-1:0] ht_d, vt_d;
  logic dirty_d, lock_d, err_d;

  // first input register plus a delayed sync copy for edge detect
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      hs1 <= 1'b0;
      hs2 <= 1'b0;
      vs1 <= 1'b0;
      vs2 <= 1'b0;
      bl1 <= 1'b0;
      r1  <= '0;
      g1  <= '0;
      b1  <= '0;
    end else begin
      hs1 <= bus.iVGA_HS;
      hs2 <= hs1;
      vs1 <= bus.iVGA_VS;
      vs2 <= vs1;
      bl1 <= bus.iVGA_BLANK;
      r1  <= bus.iVGA_R;
      g1  <= bus.iVGA_G;
      b1  <= bus.iVGA_B;
    end
  end

  assign hs_fall = hs2 & ~hs1;
  assign vs_fall = vs2 & ~vs1;

  assign h_inc = (h_cnt == CMAX) ?
    h_cnt : h_cnt + CNT_W'(1);
  assign l_inc = (line_cnt == CMAX) ?
    line_cnt : line_cnt + CNT_W'(1);

  // a line ending on this pixel is counted before any frame start
  assign cand_h = hs_fall ? h_cnt : last_h;
  assign cand_v = hs_fall ? l_inc : line_cnt;

  assign x_pix = hs_fall ? '0 : x_cnt;
  assign x_inc = (x_pix == PMAX) ?
    x_pix : x_pix + 10'd1;
  assign y_inc = (y_cnt == PMAX) ?
    y_cnt : y_cnt + 10'd1;
  assign y_pix = vs_fall ? '0 :
    ((hs_fall && line_act) ? y_inc : y_cnt);

  assign e_h = hs_fall && !skip_h &&
    (h_cnt != bus.oH_Total);
  assign e_v = vs_fall &&
    (cand_v != bus.oV_Total);
  assign e_x = bl1 && (x_pix >= XA);
  assign e_y = bl1 && (y_pix >= YA);

  // line/frame length counters and pixel coordinate tracking
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      h_cnt    <= '0;
      line_cnt <= '0;
      last_h   <= '0;
      x_cnt    <= '0;
      y_cnt    <= '0;
      line_act <= 1'b0;
      skip_h   <= 1'b0;
    end else begin
      h_cnt    <= hs_fall ? CNT_W'(1) : h_inc;
      line_cnt <= vs_fall ? '0 : cand_v;
      last_h   <= cand_h;
      x_cnt    <= bl1 ? x_inc : x_pix;
      y_cnt    <= y_pix;
      line_act <= bl1 |
        (line_act & ~hs_fall & ~vs_fall);
      skip_h   <= vs_fall | (skip_h & ~hs_fall);
    end
  end

  // lock state register and per-frame measurement history
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state_q   <= SEARCH;
      match_cnt <= '0;
      prev_h    <= '0;
      prev_v    <= '0;
      dirty     <= 1'b0;
    end else begin
      state_q   <= state_d;
      match_cnt <= cnt_d;
      prev_h    <= ph_d;
      prev_v    <= pv_d;
      dirty     <= dirty_d;
    end
  end

  // next-state, lock decision and error detection
  always_comb begin
    state_d = state_q;
    cnt_d   = match_cnt;
    ph_d    = prev_h;
    pv_d    = prev_v;
    dirty_d = dirty;
    ht_d    = bus.oH_Total;
    vt_d    = bus.oV_Total;
    lock_d  = bus.oLocked;
    err_d   = 1'b0;
    unique case (state_q)
      SEARCH: begin
        if (vs_fall) begin
          state_d = MEASURE;
          ph_d    = cand_h;
          pv_d    = '0;
          cnt_d   = '0;
          dirty_d = 1'b0;
        end
      end
      MEASURE: begin
        if (vs_fall) begin
          if (dirty) begin
            ph_d    = cand_h;
            pv_d    = '0;
            cnt_d   = '0;
            dirty_d = 1'b0;
          end else if (cand_h == prev_h &&
                       cand_v == prev_v) begin
            cnt_d = match_cnt + MW'(1);
            if (cnt_d >= LOCK_M) begin
              state_d = LOCKED;
              cnt_d   = '0;
              ht_d    = cand_h;
              vt_d    = cand_v;
              lock_d  = 1'b1;
            end
          end else begin
            cnt_d = '0;
            ph_d  = cand_h;
            pv_d  = cand_v;
          end
        end
      end
      LOCKED: begin
        if (e_h | e_v | e_x | e_y) begin
          state_d = MEASURE;
          err_d   = 1'b1;
          lock_d  = 1'b0;
          cnt_d   = '0;
          dirty_d = 1'b1;
        end
      end
      default: begin
        state_d = SEARCH;
      end
    endcase
  end

  // registered pixel, coordinate and status outputs
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      bus.oRed         <= '0;
      bus.oGreen       <= '0;
      bus.oBlue        <= '0;
      bus.oCoord_X     <= '0;
      bus.oCoord_Y     <= '0;
      bus.oPixel_Valid <= 1'b0;
      bus.oFrame_Start <= 1'b0;
      bus.oTiming_Err  <= 1'b0;
      bus.oLocked      <= 1'b0;
      bus.oH_Total     <= '0;
      bus.oV_Total     <= '0;
    end else begin
      bus.oRed         <= r1;
      bus.oGreen       <= g1;
      bus.oBlue        <= b1;
      bus.oCoord_X     <= x_pix;
      bus.oCoord_Y     <= y_pix;
      bus.oPixel_Valid <= bl1;
      bus.oFrame_Start <= vs_fall;
      bus.oTiming_Err  <= err_d;
      bus.oLocked      <= lock_d;
      bus.oH_Total     <= ht_d;
      bus.oV_Total     <= vt_d;
    end
  end

`ifdef VGA_DEC_CRC_EN
  logic [15:0] crc;
  logic [23:0] pix_d;

  assign pix_d = {r1[9:2], g1[9:2], b1[9:2]};

  function automatic logic [15:0] crc24(
    input logic [15:0] c_in,
    input logic [23:0] d
  );
    logic [15:0] c;
    logic fb;
    c = c_in;
    for (int i = 23; i >= 0; i--) begin
      fb = c[15] ^ d[i];
      c  = {c[14:0], 1'b0} ^
           (fb ? 16'h1021 : 16'h0000);
    end
    return c;
  endfunction

  // running frame CRC, handed off at each frame start
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      crc            <= 16'hFFFF;
      bus.oFrame_CRC <= '0;
    end else if (vs_fall) begin
      bus.oFrame_CRC <= crc;
      crc <= bl1 ? crc24(16'hFFFF, pix_d) :
                   16'hFFFF;
    end else if (bl1) begin
      crc <= crc24(crc, pix_d);
    end
  end
`else
  assign bus.oFrame_CRC = '0;
`endif

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Directed bench for vga_sync_decoder on a scaled-down video mode.
// 16x12 active, 24 clocks/line, 16 lines/frame, HS/VS fall together.
module tb_vga_sync_decoder;

  localparam int HA = 16;
  localparam int VA = 12;
  localparam int CW = 12;
  localparam int HT = 24;
  localparam int VT = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  vga_sync_decoder_if #(.CNT_W(CW)) bus ();

  vga_sync_decoder #(
    .H_ACTIVE(HA),
    .V_ACTIVE(VA),
    .CNT_W(CW),
    .LOCK_FRAMES(2)
  ) dut (
    .iCLK(clk),
    .iRST(rst),
    .bus(bus)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(
    input string tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  int short_ln = -1;
  int wide_ln = -1;
  int rst_ln = -1;
  int probe_x = -1;
  int probe_y = -1;
  bit yerr = 1'b0;
  bit col_zero = 1'b0;
  logic [9:0] probe_col = '0;

  int fs_cnt = 0;
  int err_cnt = 0;
  int err_wide = 0;
  logic prev_err = 1'b0;
  logic lk [0:63];
  logic [15:0] crc_fs [0:63];

  // frame-start, lock and error-pulse recorder
  always @(negedge clk) begin
    if (bus.oFrame_Start && fs_cnt < 63) begin
      fs_cnt <= fs_cnt + 1;
      lk[fs_cnt+1] <= bus.oLocked;
      crc_fs[fs_cnt+1] <= bus.oFrame_CRC;
    end
    if (bus.oTiming_Err) begin
      err_cnt <= err_cnt + 1;
      if (prev_err) err_wide <= err_wide + 1;
    end
    prev_err <= bus.oTiming_Err;
  end

  event probe_ev;
  logic [9:0] px_x, px_y, px_c;
  logic px_v;

  // two-clock latency check of a flagged pixel
  initial begin
    forever begin
      @(probe_ev);
      @(posedge clk);
      @(posedge clk);
      #1;
      chk("probe_valid", 32'(bus.oPixel_Valid), 32'(px_v));
      chk("probe_red", 32'(bus.oRed), 32'(px_c));
      chk("probe_green", 32'(bus.oGreen), 32'(px_c));
      chk("probe_blue", 32'(bus.oBlue), 32'(px_c));
      if (px_v) begin
        chk("probe_x", 32'(bus.oCoord_X), 32'(px_x));
        chk("probe_y", 32'(bus.oCoord_Y), 32'(px_y));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic pix(
    input bit hs, input bit vs, input bit bl,
    input logic [9:0] r, input logic [9:0] g,
    input logic [9:0] b
  );
    @(negedge clk);
    bus.iVGA_HS = hs;
    bus.iVGA_VS = vs;
    bus.iVGA_BLANK = bl;
    bus.iVGA_R = r;
    bus.iVGA_G = g;
    bus.iVGA_B = b;
  endtask

  task automatic do_line(input int v);
    bit hs, vs, bl, pr;
    logic [9:0] r, g, b;
    for (int h = 0; h < HT; h++) begin
      if (v == short_ln && h == HT - 1) continue;
      bl = (v < VA) &&
           (h < HA || (v == wide_ln && h == HA));
      if (yerr && v == VA && h == 0) bl = 1'b1;
      hs = !(h >= 18 && h < 22);
      vs = !((v == 13 && h >= 18) || v == 14 ||
             (v == 15 && h < 18));
      pr = (h == probe_x && v == probe_y);
      r = 10'(h * 37 + v);
      g = 10'(h + v * 3);
      b = 10'(h ^ v);
      if (pr) begin
        r = probe_col;
        g = probe_col;
        b = probe_col;
      end
      if (col_zero) begin
        r = '0;
        g = '0;
        b = '0;
      end
      pix(hs, vs, bl, r, g, b);
      if (pr) begin
        px_x = 10'(h);
        px_y = 10'(v);
        px_c = r;
        px_v = bl;
        -> probe_ev;
      end
      if (v == rst_ln && h == 8) begin
        #2 rst = 1'b1;
        #1;
        chk("arst_locked", 32'(bus.oLocked), 0);
        chk("arst_htotal", 32'(bus.oH_Total), 0);
        chk("arst_vtotal", 32'(bus.oV_Total), 0);
        chk("arst_valid", 32'(bus.oPixel_Valid), 0);
        chk("arst_red", 32'(bus.oRed), 0);
      end
      if (v == rst_ln && h == 11) rst = 1'b0;
    end
  endtask

  task automatic run(input int n);
    for (int f = 0; f < n; f++)
      for (int v = 0; v < VT; v++) do_line(v);
  endtask

  task automatic relock_chk(input string tag, input int base);
    chk({tag, "_lk1"}, 32'(lk[base+1]), 0);
    chk({tag, "_lk2"}, 32'(lk[base+2]), 0);
    chk({tag, "_lk3"}, 32'(lk[base+3]), 1);
    chk({tag, "_ht"}, 32'(bus.oH_Total), HT);
    chk({tag, "_vt"}, 32'(bus.oV_Total), VT);
  endtask

`ifdef VGA_DEC_CRC_EN
  function automatic logic [15:0] crc_px(
    input logic [15:0] c_in,
    input logic [23:0] d
  );
    logic [15:0] c;
    c = c_in;
    for (int i = 23; i >= 0; i--) begin
      if (c[15] ^ d[i]) c = {c[14:0], 1'b0} ^ 16'h1021;
      else c = {c[14:0], 1'b0};
    end
    return c;
  endfunction
`endif

  int base;
  int e0;
  logic [15:0] exp_crc;

  initial begin
    bus.iVGA_HS = 1'b1;
    bus.iVGA_VS = 1'b1;
    bus.iVGA_BLANK = 1'b0;
    bus.iVGA_R = '0;
    bus.iVGA_G = '0;
    bus.iVGA_B = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_locked", 32'(bus.oLocked), 0);
    chk("rst_htotal", 32'(bus.oH_Total), 0);
    chk("rst_vtotal", 32'(bus.oV_Total), 0);
    chk("rst_valid", 32'(bus.oPixel_Valid), 0);
    chk("rst_x", 32'(bus.oCoord_X), 0);
    chk("rst_err", 32'(bus.oTiming_Err), 0);
    chk("rst_crc", 32'(bus.oFrame_CRC), 0);
    @(negedge clk);
    rst = 1'b0;

    run(3);
    chk("init_fs", 32'(fs_cnt), 3);
    relock_chk("init", 0);
    chk("init_err", 32'(err_cnt), 0);

    probe_x = 9;
    probe_y = 10;
    probe_col = 10'h155;
    run(1);
    probe_x = 20;
    probe_y = 3;
    probe_col = 10'h2AA;
    run(1);
    probe_x = -1;
    chk("probe_locked", 32'(bus.oLocked), 1);
    chk("probe_err", 32'(err_cnt), 0);

    base = fs_cnt;
    e0 = err_cnt;
    short_ln = 5;
    run(1);
    short_ln = -1;
    chk("short_err", 32'(err_cnt - e0), 1);
    run(2);
    relock_chk("short", base);
    chk("short_err_after", 32'(err_cnt - e0), 1);
    chk("err_width", 32'(err_wide), 0);

    base = fs_cnt;
    e0 = err_cnt;
    wide_ln = 4;
    probe_x = 16;
    probe_y = 4;
    probe_col = 10'h0F3;
    run(1);
    wide_ln = -1;
    probe_x = -1;
    chk("wide_err", 32'(err_cnt - e0), 1);
    run(2);
    relock_chk("wide", base);

    base = fs_cnt;
    e0 = err_cnt;
    yerr = 1'b1;
    run(1);
    yerr = 1'b0;
    chk("yerr_err", 32'(err_cnt - e0), 1);
    run(2);
    relock_chk("yerr", base);

    base = fs_cnt;
    col_zero = 1'b1;
    run(1);
    col_zero = 1'b0;
`ifdef VGA_DEC_CRC_EN
    exp_crc = 16'hFFFF;
    for (int i = 0; i < HA * VA; i++)
      exp_crc = crc_px(exp_crc, 24'h0);
`else
    exp_crc = 16'h0000;
`endif
    chk("frame_crc", 32'(crc_fs[base+1]), 32'(exp_crc));

    base = fs_cnt;
    e0 = err_cnt;
    chk("pre_rst_locked", 32'(bus.oLocked), 1);
    rst_ln = 5;
    run(1);
    rst_ln = -1;
    run(2);
    relock_chk("mrst", base);
    chk("mrst_err", 32'(err_cnt - e0), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
